// File: rtl/masked_coeff_unmasker.sv
`timescale 1ns/1ps
// Recombines 2-share arithmetic-masked coefficients (mod 2^24) into unmasked 12-bit coefficients mod q,
// range-checks them and streams one polynomial per start. Optional share refresh: MASKED_UNMASK_REFRESH_EN.
module masked_coeff_unmasker #(
    parameter int MASKED_REG_SIZE = 24,
    parameter int NUM_COEFFS      = 256,
    parameter int Q_VAL           = 3329
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         zeroize,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2*MASKED_REG_SIZE-1:0] in_shares,
    input  logic [MASKED_REG_SIZE-1:0]   rnd_24bit,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [11:0]                  out_coeff,
    output logic                         out_last,
    output logic                         range_err,
    output logic                         busy,
    output logic                         done
);

    localparam int CNT_W   = $clog2(NUM_COEFFS + 1);
    localparam int COEFF_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]           out_cnt_q, out_cnt_d;
    logic                       range_err_q, range_err_d;
    logic [COEFF_W-1:0]         fifo_q [2];
    logic [COEFF_W-1:0]         fifo_d [2];
    logic                       wr_ptr_q, wr_ptr_d;
    logic                       rd_ptr_q, rd_ptr_d;
    logic [1:0]                 fifo_cnt_q, fifo_cnt_d;

    logic [MASKED_REG_SIZE-1:0] y0, y1, sum;
    logic [COEFF_W-1:0]         coeff_w;
    logic                       over, accept, push, pop, fifo_free, run, cnt_ok;

    assign y0 = in_shares[MASKED_REG_SIZE-1:0];
    assign y1 = in_shares[2*MASKED_REG_SIZE-1:MASKED_REG_SIZE];

`ifdef MASKED_UNMASK_REFRESH_EN
    logic                       ref_vld_q, ref_vld_d;
    logic [MASKED_REG_SIZE-1:0] ref_y0_q, ref_y0_d;
    logic [MASKED_REG_SIZE-1:0] ref_y1_q, ref_y1_d;
    logic                       ref_free;
`else
    logic                       unused_rnd;
    assign unused_rnd = ^rnd_24bit;
`endif

    assign run       = (state_q == ST_RUN);
    assign cnt_ok    = (in_cnt_q < CNT_W'(NUM_COEFFS));
    assign out_valid = (fifo_cnt_q != 2'd0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still frees a slot this cycle when the head is being taken.
    assign fifo_free = (fifo_cnt_q != 2'd2) | out_ready;

`ifdef MASKED_UNMASK_REFRESH_EN
    assign ref_free  = ~ref_vld_q | fifo_free;
    assign in_ready  = run & cnt_ok & ref_free;
    assign push      = ref_vld_q & fifo_free;
    assign sum       = ref_y0_q + ref_y1_q;
`else
    assign in_ready  = run & cnt_ok & fifo_free;
    assign push      = accept;
    assign sum       = y0 + y1;
`endif

    // The recombined sum is only ever captured in the FIFO storage, clamped to 0 when out of range.
    assign accept  = in_valid & in_ready;
    assign over    = (sum >= MASKED_REG_SIZE'(Q_VAL));
    assign coeff_w = over ? '0 : sum[COEFF_W-1:0];

    // NOTE: every always_comb output gets a default first, otherwise an unassigned path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (pop && (out_cnt_q == CNT_W'(NUM_COEFFS - 1))) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (zeroize) state_d = ST_IDLE;
    end

    always_comb begin
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        range_err_d = range_err_q;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
`ifdef MASKED_UNMASK_REFRESH_EN
        ref_vld_d   = ref_vld_q;
        ref_y0_d    = ref_y0_q;
        ref_y1_d    = ref_y1_q;
`endif

        if ((state_q == ST_IDLE) && start) begin
            in_cnt_d    = '0;
            out_cnt_d   = '0;
            range_err_d = 1'b0;
        end
        if (accept) in_cnt_d = in_cnt_q + CNT_W'(1);
        if (pop) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
            rd_ptr_d  = ~rd_ptr_q;
        end
        if (push) begin
            fifo_d[wr_ptr_q] = coeff_w;
            wr_ptr_d         = ~wr_ptr_q;
            if (over) range_err_d = 1'b1;
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

`ifdef MASKED_UNMASK_REFRESH_EN
        // Re-randomise the share split before the shares are ever added together.
        if (accept) begin
            ref_vld_d = 1'b1;
            ref_y0_d  = y0 + rnd_24bit;
            ref_y1_d  = y1 - rnd_24bit;
        end else if (push) begin
            ref_vld_d = 1'b0;
        end
`endif

        if (zeroize) begin
            in_cnt_d    = '0;
            out_cnt_d   = '0;
            range_err_d = 1'b0;
            fifo_d      = '{default: '0};
            wr_ptr_d    = 1'b0;
            rd_ptr_d    = 1'b0;
            fifo_cnt_d  = 2'd0;
`ifdef MASKED_UNMASK_REFRESH_EN
            ref_vld_d   = 1'b0;
            ref_y0_d    = '0;
            ref_y1_d    = '0;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            range_err_q <= 1'b0;
            // NOTE: the FIFO storage is reset as well because it holds unmasked secret data.
            fifo_q      <= '{default: '0};
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_cnt_q  <= 2'd0;
`ifdef MASKED_UNMASK_REFRESH_EN
            ref_vld_q   <= 1'b0;
            ref_y0_q    <= '0;
            ref_y1_q    <= '0;
`endif
        end else begin
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            range_err_q <= range_err_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
`ifdef MASKED_UNMASK_REFRESH_EN
            ref_vld_q   <= ref_vld_d;
            ref_y0_q    <= ref_y0_d;
            ref_y1_q    <= ref_y1_d;
`endif
        end
    end

    assign out_coeff = out_valid ? fifo_q[rd_ptr_q] : '0;
    assign out_last  = out_valid & (out_cnt_q == CNT_W'(NUM_COEFFS - 1));
    assign range_err = range_err_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_masked_coeff_unmasker.sv
`timescale 1ns/1ps
// Directed bench for masked_coeff_unmasker: latency, backpressure, range error, full run, zeroize.
module tb_masked_coeff_unmasker;

    localparam int NUM = 256;
`ifdef MASKED_UNMASK_REFRESH_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        zeroize = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [47:0] in_shares = '0;
    logic [23:0] rnd_24bit = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_coeff;
    logic        out_last;
    logic        range_err;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    masked_coeff_unmasker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .zeroize   (zeroize),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_shares (in_shares),
        .rnd_24bit (rnd_24bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coeff (out_coeff),
        .out_last  (out_last),
        .range_err (range_err),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rnd_24bit = 24'($urandom);
    endtask

    // Arbitrary share split whose recombination mod 2^24 is y.
    function automatic logic [47:0] split(input int y);
        logic [23:0] a, b;
        a = 24'(y * 40503 + 12345);
        b = 24'(y) - a;
        return {b, a};
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"},  in_ready,  0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_range_err"}, range_err, 0);
        check({tag, "_out_coeff"}, out_coeff, 0);
        check({tag, "_out_last"},  out_last,  0);
    endtask

    task automatic send_one(input logic [23:0] a, input logic [23:0] b, input int exp, input string tag);
        int t;
        in_shares = {b, a};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        t = 0;
        #1;
        while (!in_ready && t < 20) begin
            step();
            t++;
        end
        check({tag, "_in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            step();
            t++;
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_coeff"}, out_coeff, exp);
        step();
    endtask

    task automatic stream(input int base, input int n);
        int   sent, rcv, cyc;
        logic ir;
        sent = 0;
        rcv  = 0;
        cyc  = 0;
        out_ready = 1'b1;
        while (rcv < n && cyc < n + 50) begin
            in_valid  = (sent < n);
            in_shares = split(base + sent);
            #1;
            ir = in_ready;
            if (out_valid && out_ready) begin
                check("stream_coeff", out_coeff, base + rcv);
                check("stream_last", out_last, (base + rcv == NUM - 1));
                rcv++;
            end
            step();
            if (in_valid && ir) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_count", rcv, n);
        check("stream_cycles", cyc, n + LAT);
    endtask

    initial begin
        logic [11:0] rx[$];
        int          sent, c;
        logic        ir;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        rst_n = 1'b1;
        step();

        // Run A: first coefficient latency with carry out of bit 23 discarded
        start = 1'b1;
        step();
        start = 1'b0;
        check("runA_busy", busy, 1);
        check("runA_in_ready", in_ready, 1);
        in_shares = {24'h000006, 24'hFFFFFF};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        if (LAT == 2) begin
            check("lat_not_yet", out_valid, 0);
            step();
        end
        check("lat_valid", out_valid, 1);
        check("lat_coeff", out_coeff, 5);
        check("lat_range_err", range_err, 0);
        check("lat_last", out_last, 0);
        step();
        check("lat_popped", out_valid, 0);

        // start while running is ignored
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_in_run_busy", busy, 1);
        check("start_in_run_done", done, 0);

        // 8 back-to-back inputs, out_ready low in cycles 2-5
        sent = 0;
        c    = 0;
        while (rx.size() < 8 && c < 40) begin
            c++;
            out_ready = !(c >= 2 && c <= 5);
            in_valid  = (sent < 8);
            in_shares = split(100 + sent);
            #1;
            ir = in_ready;
            if (c == 2 + LAT) check("bp_stall", ir, 0);
            if (c == 6) check("bp_release", ir, 1);
            if (out_valid && out_ready) rx.push_back(out_coeff);
            step();
            if (in_valid && ir) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", rx.size(), 8);
        foreach (rx[i]) check("bp_order", rx[i], 100 + i);
        step();
        check("bp_no_extra", out_valid, 0);

        // Range boundary and sticky error
        send_one(24'd3328, 24'd0, 3328, "r_3328");
        check("r_3328_err", range_err, 0);
        send_one(24'd3329, 24'd0, 0, "r_3329");
        check("r_3329_err", range_err, 1);
        send_one(24'hFFFFFF, 24'd2, 1, "r_wrap");
        check("r_wrap_err", range_err, 1);
        send_one(24'h800000, 24'd0, 0, "r_big");

        // Finish run A (13 coefficients already sent)
        stream(13, NUM - 13);
        check("runA_done", done, 1);
        check("runA_done_busy", busy, 1);
        check("runA_err_held", range_err, 1);
        step();
        check("runA_done_pulse", done, 0);
        check("runA_idle", busy, 0);
        check("runA_err_idle", range_err, 1);

        // Run B: next start clears range_err, zeroize at coefficient 100
        start = 1'b1;
        step();
        start = 1'b0;
        check("runB_err_cleared", range_err, 0);
        check("runB_busy", busy, 1);
        stream(0, 100);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_shares = split(100);
        step();
        step();
        check("zq_pending", out_valid, 1);
        zeroize = 1'b1;
        start   = 1'b1;
        step();
        check_zero("zq");
        zeroize   = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("zq_idle", busy, 0);
        check("zq_empty", out_valid, 0);

        // Run C: clean full run y = i
        start = 1'b1;
        step();
        start = 1'b0;
        check("runC_busy", busy, 1);
        check("runC_err", range_err, 0);
        stream(0, NUM);
        check("runC_done", done, 1);
        check("runC_empty", out_valid, 0);
        step();
        check("runC_done_pulse", done, 0);
        check("runC_idle", busy, 0);
        check("runC_in_ready", in_ready, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
